// File: rtl/alu_arbiter.sv
// alu_arbiter -- shares one multi-cycle ALU between two requesters.
//
// Round-robin arbitration between port 0 (datapath control) and port 1
// (secondary/test master). The winner's opcode and operands are latched into
// the alu_* registers, the ALU is given one ISSUE cycle, then alu_finished is
// sampled every cycle in WAIT. The captured 64-bit result is returned with a
// one-cycle done pulse on the owner's bit. Illegal opcodes skip the ALU and
// complete immediately with err; a watchdog aborts ops that never finish.
//
// Ports
//   clock, reset_n         clock, asynchronous active-low reset
//   req0/req1              requests; held high until own done pulse
//   op0/op1, a0,b0/a1,b1   opcode and operands per port, valid while req high
//   alu_op, alu_a, alu_b   latched opcode/operands driven to the ALU
//   alu_out, alu_finished  ALU result (low 64 bits) and completion flag
//   grant                  one-hot ALU owner, 00 when idle
//   done                   one-hot, one-cycle completion pulse
//   result                 captured result, held after done
//   err                    qualifies done: illegal opcode or timeout
//   busy                   high whenever not IDLE
module alu_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [5:0]  op0,
  input  logic [5:0]  op1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [63:0] alu_out,
  input  logic        alu_finished,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic [63:0] result,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [1:0]        grant_nxt;
  logic              rr, rr_nxt;      // index of the last winner
  logic [5:0]        op_nxt;
  logic [31:0]       a_nxt, b_nxt;
  logic [63:0]       result_nxt;
  logic              err_nxt;
  logic [CNT_W-1:0]  wd, wd_nxt;

  logic              win1;
  logic [5:0]        sel_op;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h07, 6'h08, 6'h09,
      6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D: op_legal = 1'b1;
      default:                                  op_legal = 1'b0;
    endcase
  endfunction

  // With both requesting, the port that did not win last time goes next.
  assign win1   = (req0 && req1) ? ~rr : req1;
  assign sel_op = win1 ? op1 : op0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      grant  <= 2'b00;
      rr     <= 1'b1;
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      result <= '0;
      err    <= 1'b0;
      wd     <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr     <= rr_nxt;
      alu_op <= op_nxt;
      alu_a  <= a_nxt;
      alu_b  <= b_nxt;
      result <= result_nxt;
      err    <= err_nxt;
      wd     <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_nxt     = rr;
    op_nxt     = alu_op;
    a_nxt      = alu_a;
    b_nxt      = alu_b;
    result_nxt = result;
    err_nxt    = err;
    wd_nxt     = wd;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_nxt = win1 ? 2'b10 : 2'b01;
          rr_nxt    = win1;
          if (op_legal(sel_op)) begin
            op_nxt    = sel_op;
            a_nxt     = win1 ? a1 : a0;
            b_nxt     = win1 ? b1 : b0;
            state_nxt = S_ISSUE;
          end else begin
            // Never reaches the ALU; alu_* keep the previous op's values.
            result_nxt = '0;
            err_nxt    = 1'b1;
            state_nxt  = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        // alu_finished may still reflect the previous op here, so not sampled.
        wd_nxt    = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (alu_finished) begin
          result_nxt = alu_out;
          err_nxt    = 1'b0;
          state_nxt  = S_DONE;
        end else if (wd == WD_LAST) begin
          result_nxt = '0;
          err_nxt    = 1'b1;
          state_nxt  = S_DONE;
        end else begin
          wd_nxt = wd + 1'b1;
        end
      end
      S_DONE: begin
        grant_nxt = 2'b00;
        err_nxt   = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // done is the owner bit for exactly the single DONE cycle.
  assign done = (state == S_DONE) ? grant : 2'b00;
  assign busy = (state != S_IDLE);

endmodule
